data_cache: RTL

Direct-mapped, write-back, write-allocate data cache between the CPU's memory-access stage and the data memory. It serves CPU byte loads and stores, and stalls the CPU through `busywait` on a miss. On a miss it writes back a dirty victim block and then fetches the new 32-bit block from data memory. It mirrors the instruction-cache handshake already used on the fetch side.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/data_cache_array.sv | 58 +++++
 rtl/data_cache.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: controller states, field widths and a byte-select helper.
package cache_pkg;

  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int OFF_W   = 2;
  localparam int BLOCK_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } cache_state_t;

  // Pick byte 'offset' out of a block; byte 0 lives in bits [7:0].
  function automatic logic [7:0] selectByte(input logic [BLOCK_W-1:0] block,
                                            input logic [OFF_W-1:0]   offset);
    return block[{offset, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Line storage for the data cache: valid/dirty/tag/data per set, with a
// single-byte store port and a whole-block fill port sharing one index.
module data_cache_array
  import cache_pkg::*;
#(
  parameter int NSETS = 8,
  parameter int TW    = TAG_W,
  parameter int IW    = $clog2(NSETS)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [IW-1:0]      index_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TW-1:0]      tag_o,
  output logic [BLOCK_W-1:0] data_o,
  input  logic               byteWe_i,
  input  logic [OFF_W-1:0]   byteOffset_i,
  input  logic [7:0]         byteData_i,
  input  logic               fillWe_i,
  input  logic [TW-1:0]      fillTag_i,
  input  logic [BLOCK_W-1:0] fillData_i
);

  logic [NSETS-1:0]   valid_q;
  logic [NSETS-1:0]   dirty_q;
  logic [TW-1:0]      tag_q  [NSETS];
  logic [BLOCK_W-1:0] data_q [NSETS];

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign data_o  = data_q[index_i];

  // Status bits: reset invalidates everything; a fill makes the line clean, a store makes it dirty.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fillWe_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (byteWe_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Tag and data payload; never read while the valid bit is low, so it needs no reset.
  always_ff @(posedge clock_i) begin
    if (fillWe_i) begin
      tag_q[index_i]  <= fillTag_i;
      data_q[index_i] <= fillData_i;
    end else if (byteWe_i) begin
      data_q[index_i][{byteOffset_i, 3'b000} +: 8] <= byteData_i;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache. Hits complete with no
// stall; misses stall the CPU while a dirty victim is written back and the
// requested block is fetched, after which the held request hits.
module data_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = TAG_W + IDX_W + OFF_W,
  parameter int NSETS  = 1 << IDX_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      read,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         address,
  input  logic [7:0]                writedata,
  output logic [7:0]                readdata,
  output logic                      busywait,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-OFF_W-1:0]   mem_address,
  output logic [BLOCK_W-1:0]        mem_writedata,
  input  logic [BLOCK_W-1:0]        mem_readdata,
  input  logic                      mem_busywait
);

  localparam int IW = $clog2(NSETS);
  localparam int TW = ADDR_W - IW - OFF_W;
  localparam int MW = ADDR_W - OFF_W;

  logic [TW-1:0]      reqTag;
  logic [IW-1:0]      reqIndex;
  logic [OFF_W-1:0]   reqOffset;
  logic               lineValid;
  logic               lineDirty;
  logic [TW-1:0]      lineTag;
  logic [BLOCK_W-1:0] lineData;
  logic               hit;
  logic               request;
  logic               byteWe;
  logic               fillWe;
  logic               busy;
  logic               memRead;
  logic               memWrite;
  logic [MW-1:0]      memAddr;
  logic [BLOCK_W-1:0] memWdata;

  cache_state_t state_q, state_d;

  assign reqTag    = address[ADDR_W-1 -: TW];
  assign reqIndex  = address[OFF_W +: IW];
  assign reqOffset = address[OFF_W-1:0];
  assign request   = read | write;
  assign hit       = lineValid && (lineTag == reqTag);

  data_cache_array #(
    .NSETS (NSETS),
    .TW    (TW),
    .IW    (IW)
  ) u_array (
    .clock_i      (clock),
    .reset_i      (reset),
    .index_i      (reqIndex),
    .valid_o      (lineValid),
    .dirty_o      (lineDirty),
    .tag_o        (lineTag),
    .data_o       (lineData),
    .byteWe_i     (byteWe),
    .byteOffset_i (reqOffset),
    .byteData_i   (writedata),
    .fillWe_i     (fillWe),
    .fillTag_i    (reqTag),
    .fillData_i   (mem_readdata)
  );

  // Controller state register; reset abandons any transfer in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and memory-port drive; a simultaneous read+write is handled as a write.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    memAddr  = '0;
    memWdata = '0;
    byteWe   = 1'b0;
    fillWe   = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (hit) begin
            byteWe = write;
          end else begin
            busy    = 1'b1;
            state_d = (lineValid && lineDirty) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        busy     = 1'b1;
        memWrite = 1'b1;
        memAddr  = {lineTag, reqIndex};
        memWdata = lineData;
        if (!mem_busywait) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        busy    = 1'b1;
        memRead = 1'b1;
        memAddr = {reqTag, reqIndex};
        if (!mem_busywait) begin
          fillWe  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The stall is masked while reset is held so a CPU still presenting a request is released at once.
  assign busywait      = busy & ~reset;
  assign mem_read      = memRead;
  assign mem_write     = memWrite;
  assign mem_address   = memAddr;
  assign mem_writedata = memWdata;
  assign readdata      = hit ? selectByte(lineData, reqOffset) : 8'h00;

endmodule
